// File: rtl/vend_credit_ctrl.sv
// Coin-operated vending credit controller: accumulates coins, vends at PRICE_U,
// and pays change back one coin at a time through a handshaked hopper.
module vend_credit_ctrl #(
   parameter int unsigned PRICE_U    = 5,
   parameter int unsigned CREDIT_W   = 4,
   parameter int unsigned MAX_CREDIT = 12,
   parameter int unsigned VEND_CYC   = 4
) (
   input  logic                CLK50,
   input  logic                RES,
   input  logic                Q,
   input  logic                H,
   input  logic                O,
   input  logic                CAN,
   input  logic                chg_ack,
   output logic                T,
   output logic [1:0]          C,
   output logic                chg_vld,
   output logic                rej,
   output logic [CREDIT_W-1:0] credit,
   output logic [1:0]          state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      VEND   = 2'd2,
      CHANGE = 2'd3
   } state_e;

   localparam int unsigned CNT_W = (VEND_CYC > 1) ? $clog2(VEND_CYC) : 1;

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                t_q, t_d;
   logic [1:0]          c_q, c_d;
   logic                chg_vld_q, chg_vld_d;
   logic                rej_q, rej_d;

   // Coin codes double as change codes: 01 = 1 unit, 10 = 2, 11 = 4.
   function automatic int unsigned coin_val(input logic [1:0] code);
      case (code)
         2'b01:   return 1;
         2'b10:   return 2;
         2'b11:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [1:0] greedy_code(input int unsigned v);
      if (v >= 4)      return 2'b11;
      else if (v >= 2) return 2'b10;
      else if (v >= 1) return 2'b01;
      else             return 2'b00;
   endfunction

   always_comb begin
      int unsigned sum;
      int unsigned rem;
      logic [1:0]  coin_code;
      logic        coin_any;
      logic        multi;
      logic        accepted;
      // NOTE: every target gets a default first so no path can infer a latch.
      state_d   = state_q;
      credit_d  = credit_q;
      cnt_d     = cnt_q;
      t_d       = t_q;
      c_d       = c_q;
      chg_vld_d = chg_vld_q;
      rej_d     = 1'b0;
      rem       = 0;
      accepted  = 1'b0;

      if (O)      coin_code = 2'b11;
      else if (H) coin_code = 2'b10;
      else if (Q) coin_code = 2'b01;
      else        coin_code = 2'b00;
      coin_any = Q | H | O;
      multi    = (Q & H) | (Q & O) | (H & O);
      sum      = 32'(credit_q) + coin_val(coin_code);

      case (state_q)
         IDLE, ACCUM: begin
            if (coin_any) begin
               rej_d    = multi || (sum > MAX_CREDIT);
               accepted = (sum <= MAX_CREDIT);
            end
            if (!accepted) sum = 32'(credit_q);
            // A cancel wins over reaching the price: the whole sum is refunded.
            if (state_q == ACCUM && CAN) begin
               credit_d = CREDIT_W'(sum);
               if (sum != 0) begin
                  state_d   = CHANGE;
                  chg_vld_d = 1'b1;
                  c_d       = greedy_code(sum);
               end else begin
                  state_d = IDLE;
               end
            end else if (accepted && sum >= PRICE_U) begin
               state_d  = VEND;
               credit_d = CREDIT_W'(sum - PRICE_U);
               t_d      = 1'b1;
               cnt_d    = CNT_W'(VEND_CYC - 1);
            end else if (accepted) begin
               state_d  = ACCUM;
               credit_d = CREDIT_W'(sum);
            end
         end
         VEND: begin
            rej_d = coin_any;
            if (cnt_q == '0) begin
               t_d = 1'b0;
               if (credit_q != '0) begin
                  state_d   = CHANGE;
                  chg_vld_d = 1'b1;
                  c_d       = greedy_code(32'(credit_q));
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         CHANGE: begin
            rej_d = coin_any;
            if (chg_vld_q && chg_ack) begin
               rem      = 32'(credit_q) - coin_val(c_q);
               credit_d = CREDIT_W'(rem);
               if (rem == 0) begin
                  state_d   = IDLE;
                  chg_vld_d = 1'b0;
                  c_d       = 2'b00;
               end else begin
                  c_d = greedy_code(rem);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so all flops update together.
   always_ff @(posedge CLK50 or negedge RES) begin
      if (!RES) begin
         state_q   <= IDLE;
         credit_q  <= '0;
         cnt_q     <= '0;
         t_q       <= 1'b0;
         c_q       <= 2'b00;
         chg_vld_q <= 1'b0;
         rej_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         credit_q  <= credit_d;
         cnt_q     <= cnt_d;
         t_q       <= t_d;
         c_q       <= c_d;
         chg_vld_q <= chg_vld_d;
         rej_q     <= rej_d;
      end
   end

   assign T       = t_q;
   assign C       = c_q;
   assign chg_vld = chg_vld_q;
   assign rej     = rej_q;
   assign credit  = credit_q;
   assign state   = state_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Scoreboard bench for vend_credit_ctrl: default instance plus a
// MAX_CREDIT=4 / PRICE_U=4 instance for the overflow boundary.
module tb_vend_credit_ctrl;

   localparam logic [1:0] S_IDLE = 2'd0, S_ACCUM = 2'd1, S_VEND = 2'd2, S_CHANGE = 2'd3;
   // Input vector encoding {Q,H,O,CAN,ACK}
   localparam logic [4:0] NONE = 5'b00000, IQ = 5'b10000, IH = 5'b01000,
                          IO = 5'b00100, ICAN = 5'b00010, IACK = 5'b00001;

   logic clk = 1'b0;
   logic res = 1'b0;
   logic [4:0] in_a = '0, in_b = '0;

   logic       t_a, v_a, rej_a, t_b, v_b, rej_b;
   logic [1:0] c_a, st_a, c_b, st_b;
   logic [3:0] cr_a, cr_b;

   always #5 clk = ~clk;

   vend_credit_ctrl dut_a (
      .CLK50(clk), .RES(res),
      .Q(in_a[4]), .H(in_a[3]), .O(in_a[2]), .CAN(in_a[1]), .chg_ack(in_a[0]),
      .T(t_a), .C(c_a), .chg_vld(v_a), .rej(rej_a), .credit(cr_a), .state(st_a)
   );

   vend_credit_ctrl #(.PRICE_U(4), .CREDIT_W(4), .MAX_CREDIT(4), .VEND_CYC(4)) dut_b (
      .CLK50(clk), .RES(res),
      .Q(in_b[4]), .H(in_b[3]), .O(in_b[2]), .CAN(in_b[1]), .chg_ack(in_b[0]),
      .T(t_b), .C(c_b), .chg_vld(v_b), .rej(rej_b), .credit(cr_b), .state(st_b)
   );

   typedef struct {
      bit          dut;
      logic [10:0] exp;
      string       name;
   } snap_t;

   snap_t sb[$];
   int checks = 0;
   int failures = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: each clock the DUT presents a registered snapshot; pop and compare.
   always @(posedge clk) begin
      #1;
      if (sb.size() != 0) begin
         snap_t e;
         logic [10:0] act;
         e = sb.pop_front();
         act = e.dut ? {st_b, cr_b, t_b, c_b, v_b, rej_b}
                     : {st_a, cr_a, t_a, c_a, v_a, rej_a};
         check(e.name, 32'(act), 32'(e.exp));
      end
   end

   // Drive one cycle of stimulus and queue the expected post-edge outputs.
   task automatic step(input bit d, input logic [4:0] vin, input logic [1:0] st,
                       input int cr, input logic t, input logic [1:0] c,
                       input logic v, input logic rj, input string nm);
      snap_t e;
      @(negedge clk);
      if (d) in_b = vin; else in_a = vin;
      e.dut  = d;
      e.exp  = {st, 4'(cr), t, c, v, rj};
      e.name = nm;
      sb.push_back(e);
      @(posedge clk);
      #2;
      in_a = '0;
      in_b = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, checked with the clock running and reset held low.
      #12;
      check("rst_a", 32'({st_a, cr_a, t_a, c_a, v_a, rej_a}), 32'd0);
      check("rst_b", 32'({st_b, cr_b, t_b, c_b, v_b, rej_b}), 32'd0);
      @(posedge clk);
      #3;
      res = 1'b1;

      // Q, H, O -> vend with 2 left, change H
      step(0, IQ,   S_ACCUM,  1, 0, 2'b00, 0, 0, "t1_q");
      step(0, IH,   S_ACCUM,  3, 0, 2'b00, 0, 0, "t1_h");
      step(0, IO,   S_VEND,   2, 1, 2'b00, 0, 0, "t1_vend");
      for (int i = 0; i < 3; i++)
         step(0, NONE, S_VEND, 2, 1, 2'b00, 0, 0, "t1_t_hold");
      step(0, NONE, S_CHANGE, 2, 0, 2'b10, 1, 0, "t1_chg");
      step(0, NONE, S_CHANGE, 2, 0, 2'b10, 1, 0, "t1_chg_stable");
      step(0, IACK, S_IDLE,   0, 0, 2'b00, 0, 0, "t1_ack");
      step(0, IACK, S_IDLE,   0, 0, 2'b00, 0, 0, "ack_ignored_idle");
      step(0, ICAN, S_IDLE,   0, 0, 2'b00, 0, 0, "can_ignored_idle");

      // O, Q -> exact price, no change; coin during vend rejected
      step(0, IO,   S_ACCUM,  4, 0, 2'b00, 0, 0, "t2_o");
      step(0, IQ,   S_VEND,   0, 1, 2'b00, 0, 0, "t2_vend");
      step(0, IH,   S_VEND,   0, 1, 2'b00, 0, 1, "t2_coin_in_vend");
      step(0, NONE, S_VEND,   0, 1, 2'b00, 0, 0, "t2_t3");
      step(0, NONE, S_VEND,   0, 1, 2'b00, 0, 0, "t2_t4");
      step(0, NONE, S_IDLE,   0, 0, 2'b00, 0, 0, "t2_idle");

      // Simultaneous coins -> only O taken, rej pulses
      step(0, IQ|IH|IO, S_ACCUM, 4, 0, 2'b00, 0, 1, "t3_multi");
      step(0, NONE, S_ACCUM,  4, 0, 2'b00, 0, 0, "t3_rej_drop");
      step(0, ICAN, S_CHANGE, 4, 0, 2'b11, 1, 0, "t3_cancel");
      step(0, IQ,   S_CHANGE, 4, 0, 2'b11, 1, 1, "t3_coin_in_change");
      step(0, IACK, S_IDLE,   0, 0, 2'b00, 0, 0, "t3_ack");

      // H, H, CAN -> refund O held until ack
      step(0, IH,   S_ACCUM,  2, 0, 2'b00, 0, 0, "t4_h1");
      step(0, IH,   S_ACCUM,  4, 0, 2'b00, 0, 0, "t4_h2");
      step(0, ICAN, S_CHANGE, 4, 0, 2'b11, 1, 0, "t4_cancel");
      step(0, NONE, S_CHANGE, 4, 0, 2'b11, 1, 0, "t4_hold1");
      step(0, NONE, S_CHANGE, 4, 0, 2'b11, 1, 0, "t4_hold2");
      step(0, IACK, S_IDLE,   0, 0, 2'b00, 0, 0, "t4_ack");

      // Coin and cancel together; back-to-back change coins
      step(0, IQ,      S_ACCUM,  1, 0, 2'b00, 0, 0, "t5_q");
      step(0, IH|ICAN, S_CHANGE, 3, 0, 2'b10, 1, 0, "t5_h_can");
      step(0, IACK,    S_CHANGE, 1, 0, 2'b01, 1, 0, "t5_ack1");
      step(0, IACK,    S_IDLE,   0, 0, 2'b00, 0, 0, "t5_ack2");

      // Cancel with coin reaching price -> refund, no vend
      step(0, IO,      S_ACCUM,  4, 0, 2'b00, 0, 0, "t6_o");
      step(0, IO|ICAN, S_CHANGE, 8, 0, 2'b11, 1, 0, "t6_o_can");
      step(0, IACK,    S_CHANGE, 4, 0, 2'b11, 1, 0, "t6_ack1");
      step(0, IACK,    S_IDLE,   0, 0, 2'b00, 0, 0, "t6_ack2");

      // Reset during second T cycle
      step(0, IO,   S_ACCUM, 4, 0, 2'b00, 0, 0, "t7_o");
      step(0, IQ,   S_VEND,  0, 1, 2'b00, 0, 0, "t7_vend");
      step(0, NONE, S_VEND,  0, 1, 2'b00, 0, 0, "t7_t2");
      res = 1'b0;
      #1;
      check("t7_async_rst", 32'({st_a, cr_a, t_a, c_a, v_a, rej_a}), 32'd0);
      @(posedge clk);
      #3;
      res = 1'b1;
      step(0, IQ,   S_ACCUM, 1, 0, 2'b00, 0, 0, "t7_first_coin");
      step(0, ICAN, S_CHANGE, 1, 0, 2'b01, 1, 0, "t7_cancel");
      step(0, IACK, S_IDLE,   0, 0, 2'b00, 0, 0, "t7_ack");

      // MAX_CREDIT=4, PRICE_U=4 instance: overflow refusal, exact-max vend
      step(1, IQ,   S_ACCUM,  1, 0, 2'b00, 0, 0, "b_q");
      step(1, IO,   S_ACCUM,  1, 0, 2'b00, 0, 1, "b_o_overflow");
      step(1, NONE, S_ACCUM,  1, 0, 2'b00, 0, 0, "b_rej_drop");
      step(1, ICAN, S_CHANGE, 1, 0, 2'b01, 1, 0, "b_cancel");
      step(1, IACK, S_IDLE,   0, 0, 2'b00, 0, 0, "b_ack");
      step(1, IH,   S_ACCUM,  2, 0, 2'b00, 0, 0, "b_h1");
      step(1, IH,   S_VEND,   0, 1, 2'b00, 0, 0, "b_vend");
      for (int i = 0; i < 3; i++)
         step(1, NONE, S_VEND, 0, 1, 2'b00, 0, 0, "b_t_hold");
      step(1, NONE, S_IDLE,   0, 0, 2'b00, 0, 0, "b_idle");

      repeat (2) @(posedge clk);
      #2;
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
